clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Parametrised, multi-channel, runtime-programmable clock-enable generator for the CPU top level.
- Generalises the fixed divide-by-2 half-clock: NUM_CH independent channels, each with a programmable divisor.
- Each channel produces a registered near-50% divided output and a one-cycle tick strobe. Ticks are the preferred way to enable logic in the clk domain.
- Divisor updates are glitch-free: they take effect only at a period boundary.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 16, divisor and counter width in bits.
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be >= 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel run enable.
- sync_restart  input  1  one-cycle pulse; realigns all enabled channels.
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  configuration write can be accepted.
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the write.
- cfg_div  input  CNT_W  new divisor D.
- cfg_err  output  1  one-cycle pulse: write rejected.
- div_out  output  NUM_CH  divided square wave per channel.
- tick  output  NUM_CH  one-cycle strobe per channel, once per period.

Behaviour:
- Reset (asynchronous, any time, including mid-period or mid-handshake):
  - cnt=0, div=DEFAULT_DIV and pending empty for every channel.
  - div_out=0, tick=0, cfg_err=0, cfg_ready=1.
- Counter:
  - While ch_en[i]=1, cnt counts 0..D-1, then wraps to 0. The period is exactly D cycles.
- Outputs are registered decodes of the current cnt, with 1-cycle latency:
  - tick[i] <= en & (cnt==D-1).
  - div_out[i] <= en & (cnt < ceil(D/2)).
  - Result: D even gives 50% duty; D odd has the high phase one cycle longer.
- Disabled channel (ch_en[i]=0):
  - cnt is forced to 0; div_out and tick are 0 from the next cycle.
  - On re-enable, counting starts at cnt=0. The first tick appears D cycles after enable rises.
- Config handshake:
  - A write is accepted when cfg_valid & cfg_ready.
  - cfg_ready = ~pending[cfg_ch]; it is combinational in cfg_ch.
  - cfg_div < 2: the write is consumed (no stall), cfg_err pulses on the next cycle, and no state changes.
  - Valid write: cfg_div is stored in the channel's pending register and the pending flag is set.
- Applying a pending divisor (divisor becomes pending value, flag cleared, cnt=0):
  - On the first cycle in which the channel wraps (cnt==D-1 while enabled).
  - Or on any cycle in which the channel is disabled.
  - Or on a sync_restart cycle.
- Accept and wrap in the same cycle: the new value becomes pending. It is applied at the following wrap, not the current one.
- A write to a channel with a pending value stalls (cfg_ready=0). Pending values are never overwritten.
- sync_restart:
  - All enabled channels set cnt=0 in the same cycle and apply any pending divisor.
  - No tick is produced for the truncated period.
  - Disabled channels are unaffected apart from applying their pending divisor.
- Widths: cnt and div are CNT_W bits. D = 2^CNT_W - 1 is legal. The comparison against D-1 never overflows, because D >= 2.
- Channels are fully independent, except that they share the cfg port and sync_restart.

Decomposition:
- Shared package clk_div_pkg holds:
  - MIN_DIV=2.
  - The DEFAULT_DIV legality check function.
  - The ch index width helper function.
- One sub-module, clk_div_chan, is instantiated NUM_CH times in a generate loop. It contains the counter, the divisor and pending registers, and the output decode.
- The top level contains the cfg demux, the cfg_ready mux and the cfg_err register.

Test Plan:
- Reset release with ch_en=2'b01 -> ch0 tick every 2 cycles and div_out toggles every cycle; ch1 outputs stay 0.
- Write ch0 D=5 mid-period -> old period finishes; then tick period is 5 with div_out high 3 and low 2; cfg_ready[ch0]=0 until applied.
- Write D=1 and then D=0 -> cfg_err pulses once for each, divisor unchanged, no stall.
- Back-to-back writes to ch1 (D=4, then D=6) -> second write stalls until the D=4 wrap; periods observed are 4, then 6.
- Both channels at D=3 and D=7 with sync_restart pulsed -> both cnt=0 the next cycle; the first ticks arrive 3 and 7 cycles later with no spurious tick.
- Assert reset mid-period with a pending write -> outputs are 0 immediately (asynchronously); after release the divisor is DEFAULT_DIV and the pending value is lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_bank clock-enable generator.
//   MIN_DIV        : smallest divisor a channel may run with.
//   ch_idx_w()     : width of a channel index (at least one bit).
//   default_div_ok(): legality check for the reset divisor.
package clk_div_pkg;

    localparam int MIN_DIV = 2;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // The reset divisor must be at least MIN_DIV and representable in cnt_w bits.
    function automatic bit default_div_ok(input int div, input int cnt_w);
        return (div >= MIN_DIV) && ((cnt_w >= 31) || (div < (1 << cnt_w)));
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration port of clk_div_bank.
//   cfg_valid/cfg_ready : write handshake.
//   cfg_ch              : target channel of the write.
//   cfg_div             : new divisor.
//   cfg_err             : one-cycle pulse, the write was rejected.
// Handshake: a write transfers on every clock edge where cfg_valid and
// cfg_ready are both high. cfg_ready is combinational in cfg_ch and never
// depends on cfg_valid. The master holds cfg_ch/cfg_div stable while
// cfg_valid is high and not yet accepted.
interface clk_div_bank_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    localparam int CH_W = clk_div_pkg::ch_idx_w(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor and output decode.
//   clk, reset  : clock, asynchronous active-high reset.
//   en_i        : run enable; when low the counter is held at zero.
//   restart_i   : realign pulse, restarts the period at cnt=0.
//   wr_i        : store wr_div_i as pending divisor (only asserted when
//                 pending_o is low).
//   pending_o   : a pending divisor is waiting for a period boundary.
//   div_out_o   : registered near-50% divided output.
//   tick_o      : registered one-cycle strobe at the end of each period.
module clk_div_chan #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             pending_o,
    output logic             div_out_o,
    output logic             tick_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             dout_q, dout_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             realign;
    logic [CNT_W-1:0] half;

    // div_q >= 2 always, so div_q-1 never underflows.
    assign wrap    = en_i && (cnt_q == div_q - CNT_W'(1));
    // Every point where the period may (re)start at zero is also a safe
    // point to switch divisors without a glitch.
    assign realign = !en_i || restart_i || wrap;
    // ceil(D/2) without needing an extra bit: fits even for D = 2^CNT_W-1.
    assign half    = (div_q >> 1) + CNT_W'(div_q[0]);

    always_comb begin
        cnt_d  = realign ? '0 : cnt_q + CNT_W'(1);
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        if (pend_q && realign) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
        end
        // A write arriving on a wrap cycle lands after the apply check
        // above, so it waits for the following wrap.
        if (wr_i) begin
            pdiv_d = wr_div_i;
            pend_d = 1'b1;
        end
        // The period cut short by a restart does not get a tick.
        tick_d = wrap && !restart_i;
        dout_d = en_i && (cnt_q < half);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEFAULT_DIV);
            pdiv_q <= CNT_W'(DEFAULT_DIV);
            pend_q <= 1'b0;
            dout_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            dout_q <= dout_d;
            tick_q <= tick_d;
        end
    end

    assign pending_o = pend_q;
    assign div_out_o = dout_q;
    assign tick_o    = tick_q;
endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel runtime-programmable clock-enable generator.
//   clk, reset   : clock, asynchronous active-high reset.
//   ch_en        : per-channel run enable.
//   sync_restart : one-cycle pulse realigning all enabled channels.
//   cfg          : configuration write port (clk_div_bank_if.slave).
//   div_out      : divided square wave per channel.
//   tick         : one-cycle strobe per channel, once per period.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    clk_div_bank_if.slave     cfg,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    if (!default_div_ok(DEFAULT_DIV, CNT_W)) begin : g_bad_default
        $error("clk_div_bank: DEFAULT_DIV must be >= MIN_DIV and fit in CNT_W bits");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("clk_div_bank: NUM_CH must be in 1..8");
    end

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;
    logic              cfg_ready_c;
    logic              div_ok;
    logic              err_q, err_d;

    assign div_ok = cfg.cfg_div >= CNT_W'(MIN_DIV);

    // Ready/demux on the addressed channel. An index beyond NUM_CH is
    // accepted and dropped so it can never stall the port.
    always_comb begin
        cfg_ready_c = 1'b1;
        wr          = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfg_ready_c = ~pend[i];
                wr[i]       = cfg.cfg_valid & ~pend[i] & div_ok;
            end
        end
    end

    // Illegal divisors are consumed (no stall) and flagged one cycle later.
    assign err_d = cfg.cfg_valid & cfg_ready_c & ~div_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_c;
    assign cfg.cfg_err   = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .en_i      (ch_en[g]),
            .restart_i (sync_restart),
            .wr_i      (wr[g]),
            .wr_div_i  (cfg.cfg_div),
            .pending_o (pend[g]),
            .div_out_o (div_out[g]),
            .tick_o    (tick[g])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int W      = 5;   // {cfg_err, tick[1:0], div_out[1:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tick;

    clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

    clk_div_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg          (cfg_if.slave),
        .div_out      (div_out),
        .tick         (tick)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];

    // reference model of the channels
    int m_cnt[NUM_CH];
    int m_div[NUM_CH];
    int m_pdiv[NUM_CH];
    bit m_pend[NUM_CH];

    // observed period bookkeeping
    bit seen[NUM_CH];
    int last_tick_cyc[NUM_CH];
    int last_period[NUM_CH];
    int hi_acc[NUM_CH];
    int last_hi[NUM_CH];
    bit last_acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = 2;
            m_pdiv[i] = 2;
            m_pend[i] = 1'b0;
            seen[i]   = 1'b0;
            hi_acc[i] = 0;
        end
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the currently driven inputs;
    // returns the outputs the DUT must show after that edge.
    task automatic model_eval(output logic [W-1:0] e);
        int  ch;
        bit  acc;
        bit  en, wrap, bnd;
        logic [NUM_CH-1:0] e_tick, e_dout;
        logic e_err;
        ch    = int'(cfg_if.cfg_ch);
        acc   = cfg_if.cfg_valid && !m_pend[ch];
        e_err = acc && (cfg_if.cfg_div < 2);
        for (int i = 0; i < NUM_CH; i++) begin
            en        = ch_en[i];
            wrap      = en && (m_cnt[i] == m_div[i] - 1);
            e_tick[i] = wrap && !sync_restart;
            e_dout[i] = en && (m_cnt[i] < (m_div[i] + 1) / 2);
            bnd       = !en || sync_restart || wrap;
            if (m_pend[i] && bnd) begin
                m_div[i]  = m_pdiv[i];
                m_pend[i] = 1'b0;
            end
            m_cnt[i] = bnd ? 0 : m_cnt[i] + 1;
            if (acc && cfg_if.cfg_div >= 2 && ch == i) begin
                m_pdiv[i] = int'(cfg_if.cfg_div);
                m_pend[i] = 1'b1;
            end
        end
        e = {e_err, e_tick, e_dout};
    endtask

    task automatic track_ticks();
        for (int c = 0; c < NUM_CH; c++) begin
            if (tick[c]) begin
                if (seen[c]) begin
                    last_period[c] = cyc - last_tick_cyc[c];
                    last_hi[c]     = hi_acc[c] + int'(div_out[c]);
                end
                hi_acc[c]        = 0;
                last_tick_cyc[c] = cyc;
                seen[c]          = 1'b1;
            end else begin
                hi_acc[c] += int'(div_out[c]);
            end
        end
    endtask

    // One clock: check combinational ready, push expectation, clock, compare.
    task automatic step();
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        #1;
        check_val("cfg_ready", cfg_if.cfg_ready, !m_pend[int'(cfg_if.cfg_ch)]);
        last_acc = cfg_if.cfg_valid && cfg_if.cfg_ready;
        model_eval(exp_v);
        exp_q.push_back(exp_v);
        @(posedge clk);
        @(negedge clk);
        got_v = {cfg_if.cfg_err, tick, div_out};
        check_val("outputs", got_v, exp_q.pop_front());
        track_ticks();
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int c, input int d, output int stalls);
        int n;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 1'(c);
        cfg_if.cfg_div   = 16'(d);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 60);
        if (!last_acc) check_val("wr_timeout", last_acc, 1);
        stalls = n - 1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int c, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[c] && n < 60);
        if (!tick[c]) check_val("tick_timeout", tick[c], 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s, n0, n1;
        reset            = 1'b1;
        ch_en            = 2'b01;
        sync_restart     = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        model_reset();

        // reset state
        #3;
        check_val("rst_outs", {cfg_if.cfg_err, tick, div_out}, 0);
        check_val("rst_ready", cfg_if.cfg_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // default divide-by-2 on ch0, ch1 idle
        wait_tick(0, n0);
        check_val("first_tick_d2", n0, 2);
        wait_tick(0, n0);
        check_val("period_d2", last_period[0], 2);
        check_val("high_d2", last_hi[0], 1);
        check_val("ch1_idle", {tick[1], div_out[1]}, 0);

        // D=5 on ch0 mid-period: old period finishes first
        step();
        cfg_write(0, 5, s);
        check_val("wr5_stall", s, 0);
        #1;
        check_val("rdy_pending", cfg_if.cfg_ready, 0);
        wait_tick(0, n0);
        check_val("old_period", last_period[0], 2);
        wait_tick(0, n0);
        check_val("period_d5", last_period[0], 5);
        check_val("high_d5", last_hi[0], 3);

        // illegal divisors: consumed, flagged, no change
        cfg_write(0, 1, s);
        check_val("wr1_stall", s, 0);
        check_val("err_d1", cfg_if.cfg_err, 1);
        step();
        check_val("err_d1_clr", cfg_if.cfg_err, 0);
        cfg_write(0, 0, s);
        check_val("wr0_stall", s, 0);
        check_val("err_d0", cfg_if.cfg_err, 1);
        step();
        check_val("err_d0_clr", cfg_if.cfg_err, 0);
        wait_tick(0, n0);
        wait_tick(0, n0);
        check_val("period_kept", last_period[0], 5);

        // back-to-back writes to ch1: second stalls
        ch_en = 2'b11;
        step();
        cfg_write(1, 4, s);
        check_val("wr4_stall", s, 0);
        cfg_write(1, 6, s);
        check_val("wr6_stalled", s > 0, 1);
        wait_tick(1, n1);
        check_val("period_d4", last_period[1], 4);
        wait_tick(1, n1);
        check_val("period_d6", last_period[1], 6);
        check_val("high_d6", last_hi[1], 3);

        // sync_restart with D=3 / D=7
        cfg_write(0, 3, s);
        cfg_write(1, 7, s);
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        step();
        check_val("restart_cnt0", div_out, 2'b11);
        wait_tick(0, n0);
        check_val("restart_t0", n0 + 1, 3);
        wait_tick(1, n1);
        check_val("restart_t1", n0 + 1 + n1, 7);

        // async reset with a pending write
        cfg_write(0, 9, s);
        cfg_if.cfg_ch = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("async_outs", {cfg_if.cfg_err, tick, div_out}, 0);
        check_val("async_ready", cfg_if.cfg_ready, 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_tick(0, n0);
        check_val("post_rst_first", n0, 2);
        wait_tick(0, n0);
        check_val("post_rst_period", last_period[0], 2);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) ch_en = 2'($urandom_range(0, 3));
            sync_restart     = ($urandom_range(0, 19) == 0);
            cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_ch    = 1'($urandom_range(0, 1));
            cfg_if.cfg_div   = 16'($urandom_range(0, 9));
            step();
        end
        cfg_if.cfg_valid = 1'b0;
        sync_restart     = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
